// File: rtl/quad_cnt_driver_pkg.sv
// Shared definitions for the quadrature counter driver: quad state encoding,
// direction constants and the (prev,cur) step decoder.
package quad_cnt_driver_pkg;

    // State encoding is the synced {A,B} pair itself
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } quad_state_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN,
        STEP_ILL
    } step_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic quad_state_t quad_fwd(input quad_state_t s);
        quad_state_t r;
        case (s)
            S00:     r = S01;
            S01:     r = S11;
            S11:     r = S10;
            default: r = S00;
        endcase
        return r;
    endfunction

    function automatic step_t step_decode(input quad_state_t prev, input quad_state_t cur);
        step_t r;
        if (cur == prev)
            r = STEP_NONE;
        else if (cur == quad_fwd(prev))
            r = STEP_UP;
        else if (prev == quad_fwd(cur))
            r = STEP_DOWN;
        else
            r = STEP_ILL;
        return r;
    endfunction

endpackage

// File: rtl/quad_sync.sv
// Purpose: STAGES-deep flop synchroniser for one asynchronous input, resets to 0.
// Latency: STAGES cycles.
// Backpressure: none; free-running sampler.
module quad_sync #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            sr <= '0;
        else
            sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/quad_cnt_driver.sv
// Purpose: quadrature/index decoder driving a 4-bit up/down counter, with shadow check and wrap extension.
// Latency: encoder pin edge to ENPB/ENTB or LOADB low is SYNC_STAGES+1 cycles.
// Backpressure: none; counter accepts a step or load every cycle, index load wins over a step.
module quad_cnt_driver
    import quad_cnt_driver_pkg::*;
#(
    parameter int           SYNC_STAGES = 2,
    parameter logic [3:0]   RST_VAL     = 4'h0,
    parameter int           WRAP_W      = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PH_A,
    input  logic              PH_B,
    input  logic              INDEX,
    input  logic              DIR_INV,
    input  logic [3:0]        PRESET_VAL,
    input  logic [3:0]        Q_IN,
    input  logic              CLR_ERR,
    output logic [3:0]        A,
    output logic              U_DB,
    output logic              ENPB,
    output logic              ENTB,
    output logic              LOADB,
    output logic [WRAP_W-1:0] WRAP_CNT,
    output logic              QERR,
    output logic              MISMATCH
);

    localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

    logic ph_a_s, ph_b_s, index_s, index_d, idx_rise;

    quad_sync #(.STAGES(SYNC_STAGES)) u_sync_a   (.CLK(CLK), .RST(RST), .d(PH_A),  .q(ph_a_s));
    quad_sync #(.STAGES(SYNC_STAGES)) u_sync_b   (.CLK(CLK), .RST(RST), .d(PH_B),  .q(ph_b_s));
    quad_sync #(.STAGES(SYNC_STAGES)) u_sync_idx (.CLK(CLK), .RST(RST), .d(INDEX), .q(index_s));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            index_d <= 1'b0;
        else
            index_d <= index_s;
    end

    assign idx_rise = index_s & ~index_d;

    // Quadrature FSM
    quad_state_t state, state_nxt;
    step_t       step;
    logic        step_vld, step_dir, qerr_set;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= S00;
        else
            state <= state_nxt;
    end

    // The state always follows the synced pins, including after an illegal jump
    always_comb begin
        state_nxt = quad_state_t'({ph_a_s, ph_b_s});
    end

    always_comb begin
        step     = step_decode(state, state_nxt);
        step_vld = (step == STEP_UP) || (step == STEP_DOWN);
        step_dir = ((step == STEP_UP) ? DIR_UP : DIR_DOWN) ^ DIR_INV;
        qerr_set = (step == STEP_ILL);
    end

    // Counter control registers
    logic [3:0] a_q;
    logic       u_db_q, enpb_q, loadb_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q     <= RST_VAL;
            loadb_q <= 1'b0;
            enpb_q  <= 1'b1;
            u_db_q  <= DIR_UP;
        end else if (idx_rise) begin
            a_q     <= PRESET_VAL;
            loadb_q <= 1'b0;
            enpb_q  <= 1'b1;
        end else begin
            loadb_q <= 1'b1;
            enpb_q  <= ~step_vld;
            if (step_vld)
                u_db_q <= step_dir;
        end
    end

    // Shadow tracks what the counter does at the same edge it acts on our controls
    logic [3:0]        shadow, shadow_nxt;
    logic [WRAP_W-1:0] wrap_cnt, wrap_base, wrap_nxt;
    logic              wrap_inc, wrap_dec;

    always_comb begin
        shadow_nxt = shadow;
        wrap_inc   = 1'b0;
        wrap_dec   = 1'b0;
        if (!loadb_q) begin
            shadow_nxt = a_q;
        end else if (!enpb_q) begin
            if (u_db_q) begin
                shadow_nxt = shadow + 4'd1;
                wrap_inc   = (shadow == 4'hF);
            end else begin
                shadow_nxt = shadow - 4'd1;
                wrap_dec   = (shadow == 4'h0);
            end
        end
    end

    // A clear coinciding with a wrap yields +/-1, not 0
    always_comb begin
        wrap_base = (idx_rise || CLR_ERR) ? '0 : wrap_cnt;
        if (wrap_inc)
            wrap_nxt = wrap_base + WRAP_ONE;
        else if (wrap_dec)
            wrap_nxt = wrap_base - WRAP_ONE;
        else
            wrap_nxt = wrap_base;
    end

    logic chk_en, qerr_q, mismatch_q, mis_set;

    assign mis_set = chk_en && (Q_IN != shadow);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow     <= RST_VAL;
            wrap_cnt   <= '0;
            chk_en     <= 1'b0;
            qerr_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            shadow     <= shadow_nxt;
            wrap_cnt   <= wrap_nxt;
            chk_en     <= 1'b1;
            qerr_q     <= qerr_set | (qerr_q & ~CLR_ERR);
            mismatch_q <= mis_set  | (mismatch_q & ~CLR_ERR);
        end
    end

    assign A        = a_q;
    assign U_DB     = u_db_q;
    assign ENPB     = enpb_q;
    assign ENTB     = enpb_q;
    assign LOADB    = loadb_q;
    assign WRAP_CNT = wrap_cnt;
    assign QERR     = qerr_q;
    assign MISMATCH = mismatch_q;

endmodule

// File: tb/tb_quad_cnt_driver.sv
// Bench for quad_cnt_driver: behavioural 4-bit counter on Q_IN, segment table for motion,
// expected load/step events queued at stimulus time and matched by a negedge monitor.
module tb_quad_cnt_driver;

    localparam int SYNC = 2;
    localparam int WW   = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          PH_A = 1'b0, PH_B = 1'b0, INDEX = 1'b0, DIR_INV = 1'b0, CLR_ERR = 1'b0;
    logic [3:0]    PRESET_VAL = 4'h0;
    logic [3:0]    Q_IN;
    logic [3:0]    A;
    logic          U_DB, ENPB, ENTB, LOADB, QERR, MISMATCH;
    logic [WW-1:0] WRAP_CNT;

    logic [3:0] counter_q   = 4'h0;
    logic       corrupt_en  = 1'b0;
    logic [3:0] corrupt_val = 4'h0;

    int   checks = 0, errors = 0;
    int   pulse_cnt = 0, load_cnt = 0;
    logic mon_en = 1'b0;
    int   pos = 0;

    typedef struct packed {
        logic       is_load;
        logic       dir;
        logic [3:0] a;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int            n;
        int            delta;
        logic          inv;
        logic [3:0]    exp_q;
        logic [WW-1:0] exp_wrap;
        logic          exp_udb;
    } seg_t;
    seg_t segs[4];

    quad_cnt_driver #(.SYNC_STAGES(SYNC), .RST_VAL(4'h5), .WRAP_W(WW)) dut (
        .CLK(CLK), .RST(RST), .PH_A(PH_A), .PH_B(PH_B), .INDEX(INDEX),
        .DIR_INV(DIR_INV), .PRESET_VAL(PRESET_VAL), .Q_IN(Q_IN), .CLR_ERR(CLR_ERR),
        .A(A), .U_DB(U_DB), .ENPB(ENPB), .ENTB(ENTB), .LOADB(LOADB),
        .WRAP_CNT(WRAP_CNT), .QERR(QERR), .MISMATCH(MISMATCH)
    );

    always #5 CLK = ~CLK;

    // Behavioural model of the external 4-bit counter
    always @(posedge CLK) begin
        if (!LOADB)
            counter_q <= A;
        else if (!ENPB && !ENTB)
            counter_q <= U_DB ? counter_q + 4'd1 : counter_q - 4'd1;
    end

    assign Q_IN = corrupt_en ? corrupt_val : counter_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [1:0] gray(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic move(input int delta, input logic idx);
        @(negedge CLK);
        pos = (((pos + delta) % 4) + 4) % 4;
        {PH_A, PH_B} = gray(pos);
        INDEX = idx;
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (mon_en && (!LOADB || !ENPB)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: LOADB=%b ENPB=%b with nothing expected", LOADB, ENPB);
            end else begin
                e = exp_q.pop_front();
                if (!LOADB) begin
                    check("evt_is_load", 32'(e.is_load), 32'd1);
                    check("load_A", 32'(A), 32'(e.a));
                    check("load_enpb_high", 32'(ENPB), 32'd1);
                    load_cnt++;
                end else begin
                    check("evt_is_step", 32'(e.is_load), 32'd0);
                    check("step_udb", 32'(U_DB), 32'(e.dir));
                    check("step_entb", 32'(ENTB), 32'd0);
                    pulse_cnt++;
                end
            end
        end
    end

    initial begin
        int p0, l0;

        segs[0] = '{20,  1, 1'b0, 4'h9, 8'd1, 1'b1};
        segs[1] = '{10, -1, 1'b0, 4'hF, 8'd0, 1'b0};
        segs[2] = '{10, -1, 1'b1, 4'h9, 8'd1, 1'b1};
        segs[3] = '{ 3,  1, 1'b1, 4'h6, 8'd1, 1'b0};

        // Reset: counter loads RST_VAL every clock while held
        repeat (3) begin
            @(negedge CLK);
            check("rst_loadb", 32'(LOADB), 32'd0);
        end
        check("rst_A", 32'(A), 32'h5);
        check("rst_enpb", 32'(ENPB), 32'd1);
        check("rst_entb", 32'(ENTB), 32'd1);
        check("rst_udb", 32'(U_DB), 32'd1);
        check("rst_wrap", 32'(WRAP_CNT), 32'd0);
        check("rst_qerr", 32'(QERR), 32'd0);
        check("rst_mismatch", 32'(MISMATCH), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("rel_loadb", 32'(LOADB), 32'd1);
        check("rel_counter", 32'(counter_q), 32'h5);
        repeat (3) @(negedge CLK);
        check("rel_mismatch", 32'(MISMATCH), 32'd0);
        mon_en = 1'b1;

        // Motion segments
        for (int s = 0; s < 4; s++) begin
            p0 = pulse_cnt;
            @(negedge CLK);
            DIR_INV = segs[s].inv;
            for (int i = 0; i < segs[s].n; i++) begin
                int lat;
                exp_q.push_back('{is_load: 1'b0,
                                  dir: (segs[s].delta > 0) ^ segs[s].inv,
                                  a: 4'h0});
                move(segs[s].delta, 1'b0);
                lat = 0;
                for (int k = 1; k <= 8; k++) begin
                    @(negedge CLK);
                    if (!ENPB && lat == 0)
                        lat = k;
                end
                if (i == 0)
                    check("step_latency", 32'(lat), 32'(SYNC + 1));
            end
            check("seg_pulses", 32'(pulse_cnt - p0), 32'(segs[s].n));
            check("seg_count", 32'(counter_q), 32'(segs[s].exp_q));
            check("seg_wrap", 32'(WRAP_CNT), 32'(segs[s].exp_wrap));
            check("seg_udb", 32'(U_DB), 32'(segs[s].exp_udb));
            check("seg_qerr", 32'(QERR), 32'd0);
            check("seg_mismatch", 32'(MISMATCH), 32'd0);
        end

        // Index rising in the same synced cycle as a forward step: load wins
        PRESET_VAL = 4'hA;
        p0 = pulse_cnt;
        l0 = load_cnt;
        exp_q.push_back('{is_load: 1'b1, dir: 1'b0, a: 4'hA});
        move(1, 1'b1);
        repeat (8) @(negedge CLK);
        check("idx_loads", 32'(load_cnt - l0), 32'd1);
        check("idx_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("idx_count", 32'(counter_q), 32'hA);
        check("idx_wrap", 32'(WRAP_CNT), 32'd0);
        move(0, 1'b0);

        // Diagonal jump, then recovery from the new position
        DIR_INV = 1'b0;
        p0 = pulse_cnt;
        move(2, 1'b0);
        repeat (8) @(negedge CLK);
        check("ill_qerr", 32'(QERR), 32'd1);
        check("ill_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("ill_count", 32'(counter_q), 32'hA);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
        check("clr_qerr", 32'(QERR), 32'd0);
        exp_q.push_back('{is_load: 1'b0, dir: 1'b1, a: 4'h0});
        move(1, 1'b0);
        repeat (8) @(negedge CLK);
        check("post_ill_count", 32'(counter_q), 32'hB);
        check("post_ill_qerr", 32'(QERR), 32'd0);

        // Shadow mismatch: preset 4, then present 3 on Q_IN
        PRESET_VAL = 4'h4;
        exp_q.push_back('{is_load: 1'b1, dir: 1'b0, a: 4'h4});
        move(0, 1'b1);
        repeat (8) @(negedge CLK);
        move(0, 1'b0);
        repeat (2) @(negedge CLK);
        check("mm_count", 32'(counter_q), 32'h4);
        check("mm_before", 32'(MISMATCH), 32'd0);
        corrupt_val = 4'h3;
        corrupt_en  = 1'b1;
        CLR_ERR     = 1'b1;
        @(negedge CLK);
        check("mm_set_over_clr", 32'(MISMATCH), 32'd1);
        corrupt_en = 1'b0;
        CLR_ERR    = 1'b0;
        repeat (3) @(negedge CLK);
        check("mm_sticky", 32'(MISMATCH), 32'd1);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
        check("mm_clr", 32'(MISMATCH), 32'd0);

        repeat (4) @(negedge CLK);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
